// File: rtl/keycode_fifo_pkg.sv
// Shared register map and bit positions for the keycode FIFO PIO.
package keycode_fifo_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_IRQMSK = 2'd3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;

endpackage

// File: rtl/keycode_fifo_mem.sv
// Keycode storage: circular buffer with read/write pointers, occupancy count,
// push/pop handshake and flush. The head entry is read asynchronously.
module keycode_fifo_mem
  import keycode_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              ready,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop;
  logic              accept;

  assign valid  = (count != '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign pop    = valid && ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign accept = push && (!full || pop);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && !flush && accept) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/keycode_fifo_pio.sv
// Avalon-MM keycode FIFO with status/control registers and overflow flag.
// Define KEYCODE_FIFO_IRQ_EN to add the irq output and IRQMSK register.
module keycode_fifo_pio
  import keycode_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] key_data,
  output logic              key_valid,
  input  logic              key_ready
`ifdef KEYCODE_FIFO_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             wr;
  logic             wr_data;
  logic             flush;
  logic             clr_ovf;
  logic             full;
  logic             overflow;
  logic [CNT_W-1:0] count;
  logic             unused;

  assign wr      = chipselect && !write_n;
  assign wr_data = wr && (address == ADDR_DATA);
  assign flush   = wr && (address == ADDR_CTRL) && writedata[CTRL_FLUSH];
  assign clr_ovf = wr && (address == ADDR_CTRL) && writedata[CTRL_CLR_OVF];
  assign unused  = &{1'b0, writedata};

  keycode_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_data),
    .ready   (key_ready),
    .flush   (flush),
    .wr_data (writedata[DATA_W-1:0]),
    .head    (key_data),
    .valid   (key_valid),
    .full    (full),
    .count   (count)
  );

  // Clearing wins over an overflow event in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_port <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_data) out_port <= writedata[DATA_W-1:0];
      if (clr_ovf)
        overflow <= 1'b0;
      else if (wr_data && full && !(key_valid && key_ready) && !flush)
        overflow <= 1'b1;
    end
  end

`ifdef KEYCODE_FIFO_IRQ_EN
  logic [1:0] mask;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask <= 2'b00;
      irq  <= 1'b0;
    end else begin
      if (wr && (address == ADDR_IRQMSK)) mask <= writedata[1:0];
      irq <= (mask[0] && key_valid) || (mask[1] && overflow);
    end
  end
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[DATA_W-1:0] = out_port;
      ADDR_STATUS: begin
        readdata[ST_EMPTY]                 = !key_valid;
        readdata[ST_FULL]                  = full;
        readdata[ST_OVF]                   = overflow;
        readdata[ST_COUNT_LSB +: CNT_W]    = count;
      end
`ifdef KEYCODE_FIFO_IRQ_EN
      ADDR_IRQMSK: readdata[1:0] = mask;
`endif
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_keycode_fifo_pio.sv
// Directed bench for keycode_fifo_pio with a queue-based reference model
// checked every cycle. Honours KEYCODE_FIFO_IRQ_EN like the design.
module tb_keycode_fifo_pio;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic [7:0]  key_data;
  logic        key_valid;
  logic        key_ready;
`ifdef KEYCODE_FIFO_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  keycode_fifo_pio #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .key_data   (key_data),
    .key_valid  (key_valid),
    .key_ready  (key_ready)
`ifdef KEYCODE_FIFO_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of keycodes plus the register-level flags.
  int       q[$];
  bit [7:0] m_out;
  bit       m_ovf;
  bit [1:0] m_mask;
  bit       m_irq;
  bit       started = 0;

  always @(posedge clk) begin
    bit wr_, push_, flush_, clr_, pop_, was_full;
    started = 1;
    if (!reset_n) begin
      q.delete();
      m_out = 0; m_ovf = 0; m_mask = 0; m_irq = 0;
    end else begin
      wr_     = chipselect && !write_n;
      push_   = wr_ && address == 2'd0;
      flush_  = wr_ && address == 2'd2 && writedata[0];
      clr_    = wr_ && address == 2'd2 && writedata[1];
      pop_    = q.size() > 0 && key_ready;
      was_full = q.size() == DEPTH;
      m_irq   = (m_mask[0] && q.size() > 0) || (m_mask[1] && m_ovf);
      if (push_) m_out = writedata[7:0];
      if (flush_) q.delete();
      else begin
        if (pop_) void'(q.pop_front());
        if (push_) begin
          if (!was_full || pop_) q.push_back(int'(writedata[7:0]));
          else if (!clr_) m_ovf = 1;
        end
      end
      if (clr_) m_ovf = 0;
`ifdef KEYCODE_FIFO_IRQ_EN
      if (wr_ && address == 2'd3) m_mask = writedata[1:0];
`endif
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    logic [31:0] r;
    r = 0;
    case (a)
      2'd0: r = 32'(m_out);
      2'd1: r = 32'(q.size() == 0) | (32'(q.size() == DEPTH) << 1) |
                (32'(m_ovf) << 2) | (32'(q.size()) << 8);
`ifdef KEYCODE_FIFO_IRQ_EN
      2'd3: r = 32'(m_mask);
`endif
      default: r = 0;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      check("valid", 32'(key_valid), 32'(q.size() > 0));
      if (q.size() > 0) check("key_data", 32'(key_data), 32'(q[0]));
      check("out_port", 32'(out_port), 32'(m_out));
      check("readdata", readdata, exp_rd(address));
`ifdef KEYCODE_FIFO_IRQ_EN
      check("irq", 32'(irq), 32'(m_irq));
`endif
    end
  end

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 0; write_n = 1; writedata = 0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk); d = readdata;
    @(posedge clk); #1;
  endtask

  logic [31:0] rv;
  logic [7:0]  got [8];

  initial begin
    reset_n = 0; chipselect = 0; write_n = 1; address = 0; writedata = 0; key_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;

    // 1: reset state
    bus_rd(2'd1, rv);
    check("t1_status", rv, 32'h1);
    check("t1_valid", 32'(key_valid), 32'h0);
    check("t1_out_port", 32'(out_port), 32'h0);
    $display("t1 reset status=%08h", rv);

    // 2: two pushes, then pop one at a time
    bus_wr(2'd0, 32'h1A);
    bus_wr(2'd0, 32'h04);
    bus_rd(2'd1, rv);
    check("t2_status", rv, 32'h200);
    check("t2_head0", 32'(key_data), 32'h1A);
    key_ready = 1; @(posedge clk); #1 key_ready = 0;
    @(negedge clk);
    check("t2_head1", 32'(key_data), 32'h04);
    @(posedge clk); #1;
    key_ready = 1; @(posedge clk); #1 key_ready = 0;
    bus_rd(2'd1, rv);
    check("t2_empty", rv, 32'h1);
    $display("t2 push/pop status=%08h", rv);

    // 3: nine pushes into eight slots
    for (int i = 0; i < 9; i++) bus_wr(2'd0, 32'h11 + 32'(i));
    bus_rd(2'd1, rv);
    check("t3_status", rv, 32'h806);
    check("t3_out_port", 32'(out_port), 32'h19);
    check("t3_head", 32'(key_data), 32'h11);
    bus_wr(2'd2, 32'h2);
    bus_rd(2'd1, rv);
    check("t3_clr_ovf", rv, 32'h802);
    $display("t3 overflow cleared status=%08h", rv);

    // 4: full, push and pop together, then drain
    key_ready = 1;
    bus_wr(2'd0, 32'h20);
    key_ready = 0;
    bus_rd(2'd1, rv);
    check("t4_count", rv, 32'h802);
    key_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); got[i] = key_data;
      @(posedge clk); #1;
    end
    key_ready = 0;
    check("t4_first", 32'(got[0]), 32'h12);
    check("t4_sixth", 32'(got[6]), 32'h18);
    check("t4_last", 32'(got[7]), 32'h20);
    $display("t4 drained first=%02h last=%02h", got[0], got[7]);

    // 5: flush with a concurrent pop request
    bus_wr(2'd0, 32'h33);
    bus_wr(2'd0, 32'h44);
    key_ready = 1;
    bus_wr(2'd2, 32'h1);
    key_ready = 0;
    bus_rd(2'd1, rv);
    check("t5_flush", rv, 32'h1);
    $display("t5 flush status=%08h", rv);

    // empty push with ready high: push only
    key_ready = 1;
    bus_wr(2'd0, 32'h5A);
    key_ready = 0;
    bus_rd(2'd1, rv);
    check("t5_empty_push", rv, 32'h100);

    // reset mid-stream
    reset_n = 0; @(posedge clk); #1 reset_n = 1;
    @(negedge clk);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_out_port", 32'(out_port), 32'h0);
    @(posedge clk); #1;
    $display("reset mid-stream valid=%0b", key_valid);

`ifdef KEYCODE_FIFO_IRQ_EN
    // 6: not-empty interrupt
    bus_wr(2'd3, 32'h1);
    bus_wr(2'd0, 32'h2C);
    @(negedge clk);
    check("t6_irq_lag", 32'(irq), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_irq_set", 32'(irq), 32'h1);
    @(posedge clk); #1;
    key_ready = 1; @(posedge clk); #1 key_ready = 0;
    @(negedge clk);
    check("t6_irq_hold", 32'(irq), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_irq_clr", 32'(irq), 32'h0);
    @(posedge clk); #1;
    $display("t6 irq sequence done");
`else
    bus_wr(2'd3, 32'h3);
    bus_rd(2'd3, rv);
    check("t6_mask_absent", rv, 32'h0);
    $display("t6 irqmsk reads %08h", rv);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
